// File: rtl/frame_packer.sv
// Frame packer: wraps a 32-bit sample stream into host-link packets of the form
// MAGIC, INFO {frame_cnt, size}, payload words, checksum.
// Valid/ready on both sides; the output word is held in a register that also
// serves as the single skid stage, so nothing is lost under backpressure.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for a rising edge of i_frame_ready
//   S_MAGIC   | MAGIC word presented with o_sop, waiting for it to transfer
//   S_INFO    | {frame_cnt, size} presented, waiting for it to transfer
//   S_PAYLOAD | accepting payload words into the output register
//   S_CSUM    | checksum presented with o_eop, waiting for it to transfer
module frame_packer #(
  parameter logic [31:0] MAGIC  = 32'hA55A_5AA5,
  parameter int          SIZE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_ready,
  input  logic [SIZE_W-1:0] i_frame_size,
  input  logic [31:0]       i_data,
  input  logic              i_vld,
  output logic              o_rdy,
  output logic [31:0]       o_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_busy,
  output logic [SIZE_W-1:0] o_frame_cnt,
  output logic              o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAGIC,
    S_INFO,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         csum_q, csum_d;
  logic [31:0]         data_q, data_d;
  logic                vld_q, vld_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                busy_q, busy_d;
  logic [SIZE_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;

  logic fr_edge;
  logic xfer;
  logic load;
  logic rdy_out;

  assign fr_edge = i_frame_ready & ~rdy_q;
  assign xfer    = vld_q & i_rdy;
  // A payload word can enter only if the output register is empty or draining now.
  assign rdy_out = (state_q == S_PAYLOAD) && (cnt_q < size_q) && (~vld_q || i_rdy);
  assign load    = i_vld & rdy_out;

  assign o_rdy       = rdy_out;
  assign o_data      = data_q;
  assign o_vld       = vld_q;
  assign o_sop       = sop_q;
  assign o_eop       = eop_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_overrun   = overrun_q;

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d     = state_q;
    rdy_d       = i_frame_ready;
    size_d      = size_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    data_d      = data_q;
    vld_d       = vld_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    frame_cnt_d = frame_cnt_q;
    // Any edge outside IDLE is dropped, including one coinciding with end of packet.
    overrun_d   = fr_edge && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (fr_edge) begin
          size_d  = i_frame_size;
          cnt_d   = '0;
          csum_d  = '0;
          data_d  = MAGIC;
          vld_d   = 1'b1;
          sop_d   = 1'b1;
          state_d = S_MAGIC;
        end
      end
      S_MAGIC: begin
        if (xfer) begin
          data_d  = 32'({frame_cnt_q, size_q});
          sop_d   = 1'b0;
          state_d = S_INFO;
        end
      end
      S_INFO: begin
        if (xfer) begin
          if (size_q != '0) begin
            vld_d   = 1'b0;
            state_d = S_PAYLOAD;
          end else begin
            data_d  = csum_q;
            eop_d   = 1'b1;
            state_d = S_CSUM;
          end
        end
      end
      S_PAYLOAD: begin
        if (load) begin
          data_d = i_data;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + SIZE_W'(1);
          csum_d = csum_q + i_data;
        end else if (xfer) begin
          // Last payload word leaving: checksum already includes it.
          if (cnt_q == size_q) begin
            data_d  = csum_q;
            eop_d   = 1'b1;
            state_d = S_CSUM;
          end else begin
            vld_d = 1'b0;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          vld_d       = 1'b0;
          eop_d       = 1'b0;
          frame_cnt_d = frame_cnt_q + SIZE_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      size_q      <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: packet contents, backpressure hold,
// checksum wrap, overrun and mid-packet reset.
module tb_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_ready = 1'b0;
  logic [15:0] i_frame_size = '0;
  logic [31:0] i_data = '0;
  logic        i_vld = 1'b0;
  logic        o_rdy;
  logic [31:0] o_data;
  logic        o_vld;
  logic        i_rdy = 1'b0;
  logic        o_sop;
  logic        o_eop;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic        o_overrun;

  int checks = 0;
  int failures = 0;

  frame_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_ready (i_frame_ready),
    .i_frame_size  (i_frame_size),
    .i_data        (i_data),
    .i_vld         (i_vld),
    .o_rdy         (o_rdy),
    .o_data        (o_data),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_busy        (o_busy),
    .o_frame_cnt   (o_frame_cnt),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  // Transferred output words, captured at the transfer edge.
  logic [31:0] got_data[$];
  logic        got_sop[$];
  logic        got_eop[$];
  int          ovr_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && o_vld && i_rdy) begin
      got_data.push_back(o_data);
      got_sop.push_back(o_sop);
      got_eop.push_back(o_eop);
    end
    if (o_overrun) ovr_cnt++;
  end

  // Results of the last run_packet call.
  logic [31:0] pay_q[$];
  logic [31:0] exp_q[$];
  logic        snap_vld, snap_sop, snap_busy;
  logic [31:0] snap_data;
  logic        rdy_seen, busy_after, timed_out;
  int          stall_seen, stall_err;

  task automatic run_packet(input logic [15:0] size, input int rdy_mode, input int vld_mode,
                            input int drop_at, input int ovr_at);
    int          idx;
    logic        stall_prev, held_sop, held_eop, done;
    logic [31:0] held_data;
    got_data.delete(); got_sop.delete(); got_eop.delete();
    idx = 0; stall_prev = 0; held_sop = 0; held_eop = 0; held_data = '0; done = 0;
    rdy_seen = 0; stall_seen = 0; stall_err = 0;
    @(negedge clk);
    i_frame_ready = 1'b1; i_frame_size = size; i_vld = 1'b0; i_rdy = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) begin
        snap_vld = o_vld; snap_sop = o_sop; snap_data = o_data; snap_busy = o_busy;
      end
      if (stall_prev) begin
        stall_seen++;
        if (o_data !== held_data || o_vld !== 1'b1 || o_sop !== held_sop || o_eop !== held_eop)
          stall_err++;
      end
      if (got_eop.size() > 0 && got_eop[got_eop.size()-1]) begin
        done = 1;
        break;
      end
      if (c == drop_at) i_frame_ready = 1'b0;
      if (c == ovr_at) i_frame_ready = 1'b0;
      if (ovr_at >= 0 && c == ovr_at + 1) i_frame_ready = 1'b1;
      i_rdy  = (rdy_mode == 1) ? (c % 2 == 0) : 1'b1;
      i_vld  = (idx < pay_q.size()) && ((vld_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1);
      i_data = i_vld ? pay_q[idx] : 32'hDEAD_BEEF;
      #1;
      if (o_rdy) rdy_seen = 1;
      if (i_vld && o_rdy) idx++;
      stall_prev = o_vld && !i_rdy;
      held_data = o_data; held_sop = o_sop; held_eop = o_eop;
    end
    timed_out = !done;
    i_vld = 1'b0; i_rdy = 1'b1;
    repeat (3) @(negedge clk);
    busy_after = o_busy;
    i_frame_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_data, o_vld, o_rdy, o_sop, o_eop, o_busy, o_frame_cnt, o_overrun} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h vld=%b rdy=%b sop=%b eop=%b busy=%b cnt=%h ovr=%b, required all 0",
               o_data, o_vld, o_rdy, o_sop, o_eop, o_busy, o_frame_cnt, o_overrun);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_vld !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got vld=%b busy=%b, required 0 0", o_vld, o_busy);
    end
  endtask

  task automatic test_basic();
    pay_q = '{32'd1, 32'd2, 32'd3};
    exp_q = '{32'hA55A5AA5, 32'h00000003, 32'd1, 32'd2, 32'd3, 32'h00000006};
    run_packet(16'd3, 0, 0, -1, -1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout: packet never ended"); end
    checks++;
    if ({snap_vld, snap_sop, snap_busy, snap_data} !== {3'b111, 32'hA55A5AA5}) begin
      failures++;
      $display("FAIL basic_start: got vld=%b sop=%b busy=%b data=%h, required 1 1 1 a55a5aa5",
               snap_vld, snap_sop, snap_busy, snap_data);
    end
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_len: got %0d words, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_sop[i], got_eop[i], got_data[i]} !== {i == 0, i == exp_q.size()-1, exp_q[i]}) begin
        failures++;
        $display("FAIL basic_word%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                 i, got_sop[i], got_eop[i], got_data[i], i == 0, i == exp_q.size()-1, exp_q[i]);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd1) begin
      failures++; $display("FAIL basic_cnt: got %0d, required 1", o_frame_cnt);
    end
  endtask

  task automatic test_zero_size();
    pay_q.delete();
    exp_q = '{32'hA55A5AA5, 32'h00010000, 32'h00000000};
    run_packet(16'd0, 0, 0, -1, -1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL zero_timeout: packet never ended"); end
    checks++;
    if (rdy_seen !== 1'b0) begin failures++; $display("FAIL zero_rdy: o_rdy got 1, required 0"); end
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL zero_len: got %0d words, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_sop[i], got_eop[i], got_data[i]} !== {i == 0, i == exp_q.size()-1, exp_q[i]}) begin
        failures++;
        $display("FAIL zero_word%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                 i, got_sop[i], got_eop[i], got_data[i], i == 0, i == exp_q.size()-1, exp_q[i]);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd2) begin
      failures++; $display("FAIL zero_cnt: got %0d, required 2", o_frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    pay_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    exp_q = '{32'hA55A5AA5, 32'h00020004, 32'h11111111, 32'h22222222,
              32'h33333333, 32'h44444444, 32'hAAAAAAAA};
    // frame_ready falls mid-packet; the latched size must still be honoured.
    run_packet(16'd4, 1, 1, 6, -1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL bp_timeout: packet never ended"); end
    checks++;
    if (stall_seen == 0 || stall_err != 0) begin
      failures++;
      $display("FAIL bp_hold: got %0d unstable of %0d stalled cycles, required 0 of >0",
               stall_err, stall_seen);
    end
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_len: got %0d words, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_sop[i], got_eop[i], got_data[i]} !== {i == 0, i == exp_q.size()-1, exp_q[i]}) begin
        failures++;
        $display("FAIL bp_word%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                 i, got_sop[i], got_eop[i], got_data[i], i == 0, i == exp_q.size()-1, exp_q[i]);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd3) begin
      failures++; $display("FAIL bp_cnt: got %0d, required 3", o_frame_cnt);
    end
  endtask

  task automatic test_csum_wrap();
    pay_q = '{32'hFFFFFFFF, 32'h00000002};
    run_packet(16'd2, 0, 0, -1, -1);
    checks++;
    if (got_data.size() != 5) begin
      failures++; $display("FAIL wrap_len: got %0d words, required 5", got_data.size());
    end else begin
      checks++;
      if (got_data[1] !== 32'h00030002) begin
        failures++; $display("FAIL wrap_info: got %h, required 00030002", got_data[1]);
      end
      checks++;
      if (got_data[4] !== 32'h00000001 || got_eop[4] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_csum: got %h eop=%b, required 00000001 eop=1", got_data[4], got_eop[4]);
      end
    end
  endtask

  task automatic test_overrun();
    ovr_cnt = 0;
    pay_q = '{32'd5, 32'd6, 32'd7};
    exp_q = '{32'hA55A5AA5, 32'h00040003, 32'd5, 32'd6, 32'd7, 32'h00000012};
    run_packet(16'd3, 0, 0, -1, 1);
    checks++;
    if (ovr_cnt != 1) begin
      failures++; $display("FAIL ovr_pulses: got %0d, required 1", ovr_cnt);
    end
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovr_len: got %0d words, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_sop[i], got_eop[i], got_data[i]} !== {i == 0, i == exp_q.size()-1, exp_q[i]}) begin
        failures++;
        $display("FAIL ovr_word%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                 i, got_sop[i], got_eop[i], got_data[i], i == 0, i == exp_q.size()-1, exp_q[i]);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd5) begin
      failures++; $display("FAIL ovr_cnt: got %0d, required 5", o_frame_cnt);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++; $display("FAIL ovr_restart: busy got %b after packet, required 0", busy_after);
    end
  endtask

  task automatic test_reset_mid();
    i_rdy = 1'b1;
    @(negedge clk);
    i_frame_ready = 1'b1; i_frame_size = 16'd4; i_vld = 1'b1; i_data = 32'h100;
    repeat (4) begin
      @(negedge clk);
      i_data = i_data + 32'd1;
    end
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL rmid_busy: got %b, required 1", o_busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data, o_vld, o_rdy, o_sop, o_eop, o_busy, o_frame_cnt, o_overrun} !== 54'd0) begin
      failures++;
      $display("FAIL rmid_outputs: got data=%h vld=%b rdy=%b sop=%b eop=%b busy=%b cnt=%h ovr=%b, required all 0",
               o_data, o_vld, o_rdy, o_sop, o_eop, o_busy, o_frame_cnt, o_overrun);
    end
    i_frame_ready = 1'b0; i_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got_data.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (o_vld !== 1'b0 || o_busy !== 1'b0 || got_data.size() != 0) begin
      failures++;
      $display("FAIL rmid_idle: got vld=%b busy=%b words=%0d, required 0 0 0",
               o_vld, o_busy, got_data.size());
    end
    pay_q = '{32'h0000000A};
    exp_q = '{32'hA55A5AA5, 32'h00000001, 32'h0000000A, 32'h0000000A};
    run_packet(16'd1, 0, 0, -1, -1);
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rmid_len: got %0d words, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if ({got_sop[i], got_eop[i], got_data[i]} !== {i == 0, i == exp_q.size()-1, exp_q[i]}) begin
        failures++;
        $display("FAIL rmid_word%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                 i, got_sop[i], got_eop[i], got_data[i], i == 0, i == exp_q.size()-1, exp_q[i]);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd1) begin
      failures++; $display("FAIL rmid_cnt: got %0d, required 1", o_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_backpressure();
    test_csum_wrap();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
